multicycle_core: RTL and testbench
==================================

Name: multicycle_core

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS datapath. Each instruction executes over 2–5 states of a control FSM.
- Fetch and data accesses share one handshaked memory port, so the core tolerates wait states.
- Register file, ALU, sign extension and next-PC logic are internal.
- Sits between the system top and a unified instruction/data memory.

Parameters:
- XLEN, 32, datapath and register width; legal values 32 or 64. Instructions are always 32 bits, taken from mem_rdata[31:0].
- NREGS, 32, number of architectural registers (power of two, max 32). Register fields index modulo NREGS.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- mem_req  output  1  memory transaction request
- mem_we  output  1  1 = write, 0 = read; valid while mem_req is high
- mem_addr  output  XLEN  byte address, word aligned
- mem_wdata  output  XLEN  store data
- mem_rdata  input  XLEN  read data; valid in the cycle mem_req && mem_ready
- mem_ready  input  1  transaction completes in any cycle where mem_req && mem_ready
- pc_out  output  XLEN  current PC
- instr_out  output  32  instruction register
- alu_out  output  XLEN  ALU result register
- retire  output  1  one-cycle pulse in the final cycle of each instruction
- halted  output  1  core stopped on an illegal or misaligned instruction

Behaviour:
- Reset (reset=0 at a clk edge):
  - PC=RESET_PC; IR=0; ALU register=0; all registers=0; state=FETCH.
  - mem_req=0, retire=0, halted=0 while reset is held.
  - Reset mid-transaction abandons the access; memory must accept mem_req dropping.
- Register 0 reads as 0; writes to it are discarded.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - Drive mem_req=1, mem_we=0, mem_addr=PC. Hold until mem_ready.
  - On completion: IR<=mem_rdata[31:0], PC<=PC+4, go to DECODE.
- DECODE:
  - Latch A=R[rs], B=R[rt], imm=sign_extend(IR[15:0]) to XLEN.
  - j (op 0x02): PC<={PC[XLEN-1:28], IR[25:0], 2'b00}, retire=1, go to FETCH.
  - Unsupported opcode: go to HALT.
  - Otherwise go to EXEC.
- EXEC:
  - R-type (op 0x00), by funct:
    - 0x20 add, 0x22 sub, 0x24 and, 0x25 or: wrapping XLEN-bit arithmetic, no overflow trap.
    - 0x2A slt: signed compare.
    - Any other funct: go to HALT.
  - addi (0x08): A+imm.
  - lw (0x23) / sw (0x2B): address=A+imm. If address[1:0]≠0, go to HALT; otherwise go to MEM.
  - beq (0x04): if A==B, PC<=PC+(imm<<2), where PC already holds PC+4. Retire, go to FETCH.
  - R-type and addi go to WB.
- MEM:
  - lw: mem_req=1, mem_we=0. sw: mem_req=1, mem_we=1, mem_wdata=B.
  - mem_addr=ALU register; hold until mem_ready.
  - lw: latch MDR, go to WB. sw: retire, go to FETCH.
- WB:
  - R-type writes R[rd]; addi and lw write R[rt] (lw writes MDR); then retire, go to FETCH.
- Cycle counts with zero wait states: j=2, beq=3, sw=4, R-type/addi=4, lw=5. Each wait cycle adds 1.
- HALT:
  - halted=1, mem_req=0, no state changes. Leave only via reset.
  - A halting instruction does not retire.
- A write-back to register r followed by a read of r in the next instruction's DECODE must return the new value.

Test Plan:
- Zero-wait memory; program addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2. Expect R3=2, 3 retire pulses, 12 cycles after reset release.
- sw $3,8($0) then lw $4,8($0). Expect write beat at address 8 with data 2, then R4=2. lw takes 5 cycles.
- beq $1,$1,+2 at PC=0x10. Expect next fetch at 0x1C. With unequal operands, expect next fetch at 0x14; beq takes 3 cycles either way.
- j 0x40 at PC=0x20. Expect next fetch address 0x100, retire after 2 cycles.
- mem_ready low for 3 cycles during fetch and during lw. Expect mem_req and mem_addr held stable, and each access stretched by exactly 3 cycles.
- Opcode 0x3F, and lw to address 6. Expect halted=1 in both cases, no retire, mem_req=0. reset=0 for one edge then released: expect fetch from RESET_PC and halted=0.

Source files
------------

// File: rtl/multicycle_core.sv
// multicycle_core
//    Multi-cycle MIPS-subset core. Each instruction walks a control FSM
//    (FETCH, DECODE, EXEC, MEM, WB) over 2 to 5 states. Instruction fetch
//    and load/store share a single request/ready memory port, so any number
//    of wait states is tolerated. An unsupported opcode, an unsupported
//    R-type funct or a misaligned load/store parks the core in HALT, which
//    only reset can leave.
//
// Ports
//    clk        rising-edge clock
//    reset      synchronous, active-low reset
//    mem_req    memory transaction request
//    mem_we     1 = write, 0 = read (valid with mem_req)
//    mem_addr   word-aligned byte address
//    mem_wdata  store data
//    mem_rdata  read data, consumed when mem_req && mem_ready
//    mem_ready  completes the current transaction
//    pc_out     current PC
//    instr_out  instruction register
//    alu_out    ALU result register
//    retire     one-cycle pulse in the last cycle of each instruction
//    halted     core stopped on an illegal or misaligned instruction
module multicycle_core #(
   parameter int              XLEN     = 32,
   parameter int              NREGS    = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ready,
   output logic [XLEN-1:0] pc_out,
   output logic [31:0]     instr_out,
   output logic [XLEN-1:0] alu_out,
   output logic            retire,
   output logic            halted
);

   localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_EXEC   = 3'd2;
   localparam logic [2:0] ST_MEM    = 3'd3;
   localparam logic [2:0] ST_WB     = 3'd4;
   localparam logic [2:0] ST_HALT   = 3'd5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   logic [2:0]      state_reg, state_next;
   logic [XLEN-1:0] pc_reg, pc_next;
   logic [31:0]     ir_reg, ir_next;
   logic [XLEN-1:0] alu_reg, alu_next;
   logic [XLEN-1:0] a_reg, a_next;
   logic [XLEN-1:0] b_reg, b_next;
   logic [XLEN-1:0] imm_reg, imm_next;
   logic [XLEN-1:0] mdr_reg, mdr_next;
   logic [XLEN-1:0] regs_reg [NREGS];

   logic [5:0]      opcode, funct;
   logic [RW-1:0]   rs_idx, rt_idx, rd_idx;
   logic [XLEN-1:0] imm_ext, sum_ai;
   logic            retire_int, wb_en;
   logic [RW-1:0]   wb_idx;
   logic [XLEN-1:0] wb_data;

   // Register fields are truncated, so indices wrap modulo NREGS.
   assign opcode  = ir_reg[31:26];
   assign funct   = ir_reg[5:0];
   assign rs_idx  = ir_reg[21 +: RW];
   assign rt_idx  = ir_reg[16 +: RW];
   assign rd_idx  = ir_reg[11 +: RW];
   assign imm_ext = {{(XLEN-16){ir_reg[15]}}, ir_reg[15:0]};
   assign sum_ai  = a_reg + imm_reg;

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      ir_next    = ir_reg;
      alu_next   = alu_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      imm_next   = imm_reg;
      mdr_next   = mdr_reg;
      retire_int = 1'b0;
      wb_en      = 1'b0;
      wb_idx     = rt_idx;
      wb_data    = alu_reg;
      case (state_reg)
         ST_FETCH: begin
            if (mem_ready) begin
               ir_next    = mem_rdata[31:0];
               pc_next    = pc_reg + XLEN'(4);
               state_next = ST_DECODE;
            end
         end
         ST_DECODE: begin
            a_next   = regs_reg[rs_idx];
            b_next   = regs_reg[rt_idx];
            imm_next = imm_ext;
            case (opcode)
               OP_J: begin
                  // pc_reg already holds PC+4, so the region bits come from it.
                  pc_next    = {pc_reg[XLEN-1:28], ir_reg[25:0], 2'b00};
                  retire_int = 1'b1;
                  state_next = ST_FETCH;
               end
               OP_RTYPE, OP_ADDI, OP_BEQ, OP_LW, OP_SW: state_next = ST_EXEC;
               default: state_next = ST_HALT;
            endcase
         end
         ST_EXEC: begin
            case (opcode)
               OP_RTYPE: begin
                  state_next = ST_WB;
                  case (funct)
                     FN_ADD:  alu_next = a_reg + b_reg;
                     FN_SUB:  alu_next = a_reg - b_reg;
                     FN_AND:  alu_next = a_reg & b_reg;
                     FN_OR:   alu_next = a_reg | b_reg;
                     FN_SLT:  alu_next = {{(XLEN-1){1'b0}}, ($signed(a_reg) < $signed(b_reg))};
                     default: state_next = ST_HALT;
                  endcase
               end
               OP_ADDI: begin
                  alu_next   = sum_ai;
                  state_next = ST_WB;
               end
               OP_LW, OP_SW: begin
                  alu_next   = sum_ai;
                  state_next = (sum_ai[1:0] != 2'b00) ? ST_HALT : ST_MEM;
               end
               OP_BEQ: begin
                  if (a_reg == b_reg) begin
                     pc_next = pc_reg + (imm_reg << 2);
                  end
                  retire_int = 1'b1;
                  state_next = ST_FETCH;
               end
               default: state_next = ST_HALT;
            endcase
         end
         ST_MEM: begin
            if (mem_ready) begin
               if (opcode == OP_SW) begin
                  retire_int = 1'b1;
                  state_next = ST_FETCH;
               end else begin
                  mdr_next   = mem_rdata;
                  state_next = ST_WB;
               end
            end
         end
         ST_WB: begin
            wb_en      = 1'b1;
            retire_int = 1'b1;
            state_next = ST_FETCH;
            if (opcode == OP_RTYPE) begin
               wb_idx = rd_idx;
            end
            if (opcode == OP_LW) begin
               wb_data = mdr_reg;
            end
         end
         default: ;  // HALT holds every register
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= ST_FETCH;
         pc_reg    <= RESET_PC;
         ir_reg    <= '0;
         alu_reg   <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         imm_reg   <= '0;
         mdr_reg   <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         ir_reg    <= ir_next;
         alu_reg   <= alu_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         imm_reg   <= imm_next;
         mdr_reg   <= mdr_next;
      end
   end

   // Entry 0 is cleared by reset and never written, so it always reads 0.
   // Write-back lands at the end of WB, at least one FETCH cycle before the
   // next DECODE reads the file, so no bypass path is needed.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_reg[i] <= '0;
         end
      end else if (wb_en && (wb_idx != '0)) begin
         regs_reg[wb_idx] <= wb_data;
      end
   end

   // Outputs are gated while reset is held so nothing leaks before the edge.
   assign mem_req   = reset && ((state_reg == ST_FETCH) || (state_reg == ST_MEM));
   assign mem_we    = reset && (state_reg == ST_MEM) && (opcode == OP_SW);
   assign mem_addr  = (state_reg == ST_FETCH) ? pc_reg : alu_reg;
   assign mem_wdata = b_reg;
   assign retire    = reset && retire_int;
   assign halted    = reset && (state_reg == ST_HALT);
   assign pc_out    = pc_reg;
   assign instr_out = ir_reg;
   assign alu_out   = alu_reg;

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core
//    Self-checking bench for multicycle_core. A unified memory model answers
//    the core's port with configurable wait states; an instruction-level
//    reference (one call per instruction) predicts fetch/data transactions,
//    cycle counts, ALU results and halts.
module tb_multicycle_core;

   localparam logic [31:0] RST_PC  = 32'h0;
   localparam logic [31:0] HALT_OP = 32'hFC000000;

   logic        clk, reset, mem_req, mem_we, mem_ready, retire, halted;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out, instr_out, alu_out;

   multicycle_core #(.XLEN(32), .NREGS(32), .RESET_PC(RST_PC)) dut (
      .clk       (clk),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .pc_out    (pc_out),
      .instr_out (instr_out),
      .alu_out   (alu_out),
      .retire    (retire),
      .halted    (halted)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [31:0] dut_mem [1024];
   logic [31:0] m_mem   [1024];
   logic [31:0] m_regs  [32];
   logic [31:0] m_pc;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] e_fetch, e_ins, e_daddr, e_wdata, e_alu;
   bit          e_halt, e_data, e_we, e_has_alu;
   int          e_base;

   logic [31:0] t_addr [$];
   logic [31:0] t_wdata [$];
   bit          t_we [$];
   int          first3_cyc;
   bit          saw_halt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
      return {op, 5'(rs), 5'(rt), imm};
   endfunction

   function automatic logic [31:0] enc_j(input int idx);
      return {6'h02, 26'(idx)};
   endfunction

   // Instruction-level reference: executes one instruction on m_* state.
   task automatic model_step();
      logic [31:0] ins, a, b, imm, ea, npc;
      e_fetch = m_pc;
      ins = m_mem[m_pc[11:2]];
      e_ins = ins;
      npc = m_pc + 32'd4;
      a = m_regs[ins[25:21]];
      b = m_regs[ins[20:16]];
      imm = {{16{ins[15]}}, ins[15:0]};
      e_halt = 0; e_data = 0; e_we = 0; e_has_alu = 0; e_base = 0;
      e_daddr = '0; e_wdata = '0; e_alu = '0;
      case (ins[31:26])
         6'h02: begin npc = {npc[31:28], ins[25:0], 2'b00}; e_base = 2; end
         6'h04: begin if (a == b) npc = npc + (imm << 2); e_base = 3; end
         6'h08: begin e_alu = a + imm; e_has_alu = 1; e_base = 4; end
         6'h00: begin
            e_has_alu = 1; e_base = 4;
            case (ins[5:0])
               6'h20: e_alu = a + b;
               6'h22: e_alu = a - b;
               6'h24: e_alu = a & b;
               6'h25: e_alu = a | b;
               6'h2A: e_alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               default: begin e_halt = 1; e_has_alu = 0; end
            endcase
         end
         6'h23, 6'h2B: begin
            ea = a + imm;
            if (ea[1:0] != 2'b00) e_halt = 1;
            else begin
               e_data = 1; e_daddr = ea; e_we = (ins[31:26] == 6'h2B);
               if (e_we) begin
                  e_wdata = b; e_base = 4;
                  m_mem[ea[11:2]] = b;
               end else begin
                  e_base = 5;
                  if (ins[20:16] != 0) m_regs[ins[20:16]] = m_mem[ea[11:2]];
               end
            end
         end
         default: e_halt = 1;
      endcase
      if (e_has_alu && !e_halt) begin
         if (ins[31:26] == 6'h00) begin
            if (ins[15:11] != 0) m_regs[ins[15:11]] = e_alu;
         end else if (ins[20:16] != 0) begin
            m_regs[ins[20:16]] = e_alu;
         end
      end
      if (!e_halt) m_pc = npc;
   endtask

   task automatic fill_mem();
      for (int i = 0; i < 1024; i++) dut_mem[i] = HALT_OP;
      for (int i = 128; i < 144; i++) dut_mem[i] = $urandom;
   endtask

   // mode 0: zero wait, 1: random waits, 2: exactly 3 waits per access
   task automatic run_program(input int mode);
      int cyc, waits, low_run, n_ret, tot;
      bit stall_q, we_q, stop, rdy;
      logic [31:0] addr_q;
      for (int i = 0; i < 1024; i++) m_mem[i] = dut_mem[i];
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_pc = RST_PC;
      t_addr.delete(); t_wdata.delete(); t_we.delete();
      cyc = 0; waits = 0; low_run = 0; n_ret = 0; tot = 0;
      stall_q = 0; we_q = 0; addr_q = '0; stop = 0; first3_cyc = 0; saw_halt = 0;
      reset = 1'b0;
      mem_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_pc", pc_out, RST_PC);
      check("rst_ir", instr_out, 0);
      check("rst_alu", alu_out, 0);
      check("rst_req", 32'(mem_req), 0);
      check("rst_retire", 32'(retire), 0);
      check("rst_halted", 32'(halted), 0);
      while (!stop) begin
         @(negedge clk);
         reset = 1'b1;
         #1;
         rdy = 1'b1;
         if (mode == 1) rdy = !(mem_req && low_run < 4 && $urandom_range(0, 2) == 0);
         if (mode == 2) rdy = !(mem_req && low_run < 3);
         low_run = rdy ? 0 : low_run + 1;
         mem_ready = rdy;
         #1;
         if (mem_req && !mem_we && mem_ready) mem_rdata = dut_mem[mem_addr[11:2]];
         else mem_rdata = $urandom;
         #1;
         cyc++; tot++;
         if (stall_q) begin
            check("hold_req", 32'(mem_req), 1);
            check("hold_addr", mem_addr, addr_q);
            check("hold_we", 32'(mem_we), 32'(we_q));
         end
         stall_q = mem_req && !mem_ready;
         addr_q = mem_addr;
         we_q = mem_we;
         if (mem_req && !mem_ready) waits++;
         if (mem_req && mem_ready) begin
            t_addr.push_back(mem_addr); t_we.push_back(mem_we); t_wdata.push_back(mem_wdata);
            if (mem_we) dut_mem[mem_addr[11:2]] = mem_wdata;
         end
         if (retire || halted) begin
            model_step();
            $display("instr pc=%08h ins=%08h cycles=%0d waits=%0d halted=%0d", e_fetch, e_ins, cyc, waits, halted);
            check("halt", 32'(halted), 32'(e_halt));
            check("txn_count", 32'(t_addr.size()), e_data ? 2 : 1);
            if (t_addr.size() >= 1) begin
               check("fetch_addr", t_addr[0], e_fetch);
               check("fetch_we", 32'(t_we[0]), 0);
            end
            if (e_data && t_addr.size() >= 2) begin
               check("data_addr", t_addr[1], e_daddr);
               check("data_we", 32'(t_we[1]), 32'(e_we));
               if (e_we) check("store_data", t_wdata[1], e_wdata);
            end
            if (!e_halt && !halted) begin
               check("cycles", 32'(cyc), 32'(e_base + waits));
               if (mode == 2) check("stretch3", 32'(cyc), 32'(e_base + 3 * (e_data ? 2 : 1)));
               if (e_has_alu) check("alu_out", alu_out, e_alu);
            end
            n_ret++;
            if (n_ret == 3) first3_cyc = tot;
            if (halted || e_halt || n_ret > 300) begin
               stop = 1;
               saw_halt = halted;
            end
            cyc = 0; waits = 0;
            t_addr.delete(); t_wdata.delete(); t_we.delete();
         end else if (cyc > 80) begin
            check("instr_timeout", 32'(retire | halted), 1);
            stop = 1;
         end
      end
      if (saw_halt) begin
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ready = 1'(($urandom_range(0, 1)));
            #1;
            check("halt_stay", 32'(halted), 1);
            check("halt_req", 32'(mem_req), 0);
            check("halt_retire", 32'(retire), 0);
         end
      end
   endtask

   task automatic load_prog_a();
      fill_mem();
      dut_mem[0]  = enc_i(6'h08, 0, 1, 16'd5);
      dut_mem[1]  = enc_i(6'h08, 0, 2, 16'hFFFD);
      dut_mem[2]  = enc_r(1, 2, 3, 6'h20);
      dut_mem[3]  = enc_i(6'h2B, 0, 3, 16'd8);
      dut_mem[4]  = enc_i(6'h04, 1, 1, 16'd2);
      dut_mem[5]  = enc_i(6'h08, 0, 5, 16'd1);
      dut_mem[6]  = enc_i(6'h08, 0, 5, 16'd2);
      dut_mem[7]  = enc_i(6'h23, 0, 4, 16'd8);
      dut_mem[8]  = enc_j(32'h40);
      dut_mem[64] = enc_i(6'h04, 1, 2, 16'd2);
      dut_mem[65] = enc_i(6'h2B, 0, 4, 16'd12);
      dut_mem[66] = enc_r(1, 2, 6, 6'h2A);
      dut_mem[67] = enc_r(2, 1, 7, 6'h2A);
      dut_mem[68] = enc_r(1, 2, 8, 6'h22);
   endtask

   function automatic logic [31:0] rand_instr(input int k);
      logic [5:0] fn_tab [5];
      int sel, rs, rt, rd;
      fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24; fn_tab[3] = 6'h25; fn_tab[4] = 6'h2A;
      sel = $urandom_range(0, 9);
      rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
      case (sel)
         0, 1, 2: return enc_r(rs, rt, rd, fn_tab[$urandom_range(0, 4)]);
         3:       return enc_i(6'h08, rs, rt, 16'($urandom));
         4:       return enc_i(6'h23, 0, rt, 16'(32'h200 + 4 * $urandom_range(0, 15)));
         5:       return enc_i(6'h2B, 0, rt, 16'(32'h200 + 4 * $urandom_range(0, 15)));
         6:       return enc_i(6'h04, $urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom_range(0, 3)));
         7:       return enc_j(k + 1 + $urandom_range(0, 3));
         default: return enc_i(6'h08, rs, rt, 16'($urandom_range(0, 20)));
      endcase
   endfunction

   initial begin
      reset = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = '0;

      // Directed program, zero wait states
      load_prog_a();
      run_program(0);
      check("first3_cycles", 32'(first3_cyc), 12);
      check("sw8_data", dut_mem[2], 2);
      check("r4_store", dut_mem[3], 2);
      check("prog_a_halted", 32'(saw_halt), 1);

      // Same program, every access stretched by exactly 3 cycles
      load_prog_a();
      run_program(2);
      check("r4_store_w", dut_mem[3], 2);

      // Misaligned load halts; one-edge reset restarts from RESET_PC
      fill_mem();
      dut_mem[0] = enc_i(6'h08, 0, 1, 16'd6);
      dut_mem[1] = enc_i(6'h23, 1, 2, 16'd0);
      run_program(0);
      check("misaligned_halted", 32'(saw_halt), 1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_hold_req", 32'(mem_req), 0);
      check("rst_hold_halted", 32'(halted), 0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("restart_req", 32'(mem_req), 1);
      check("restart_addr", mem_addr, RST_PC);
      check("restart_halted", 32'(halted), 0);

      // Illegal opcode at the reset vector
      fill_mem();
      run_program(1);
      check("illegal_op_halted", 32'(saw_halt), 1);

      // Random straight-line programs with forward control flow
      for (int p = 0; p < 30; p++) begin
         int n = $urandom_range(10, 24);
         fill_mem();
         for (int k = 0; k < n; k++) dut_mem[k] = rand_instr(k);
         case ($urandom_range(0, 2))
            0:       dut_mem[n] = HALT_OP;
            1:       dut_mem[n] = enc_r(1, 2, 3, 6'h3F);
            default: dut_mem[n] = enc_i(6'h23, 0, 1, 16'h0202);
         endcase
         run_program(1);
         for (int i = 128; i < 144; i++) check("dmem", dut_mem[i], m_mem[i]);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
